seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 4-digit hex 7-segment scanner with frame-synchronous load buffer
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV     = 16'd10_000,
  parameter logic [7:0]  BLANK_CYCLES = 8'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [6:0]  seg,
  output logic [3:0]  dig_en,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [15:0] DRIVE_LAST = SCAN_DIV - 16'd1;
  localparam logic [15:0] BLANK_LAST = {8'd0, BLANK_CYCLES} - 16'd1;
  localparam logic        NO_BLANK   = (BLANK_CYCLES == 8'd0);

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] active, active_n, pending;
  logic        pending_full;
  logic [6:0]  seg_n;
  logic [3:0]  dig_en_n;
  logic        frame_done_n;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd0: nibble = v[3:0];
      2'd1: nibble = v[7:4];
      2'd2: nibble = v[11:8];
      default: nibble = v[15:12];
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd0: lead_zero = 1'b0;
      2'd1: lead_zero = (v[15:4] == 12'd0);
      2'd2: lead_zero = (v[15:8] == 8'd0);
      default: lead_zero = (v[15:12] == 4'd0);
    endcase
  endfunction
`endif

  assign load_ready = ~pending_full;

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    active_n = (frame_done && pending_full) ? pending : active;
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    if (!enable) begin
      state_n = IDLE;
      idx_n   = 2'd0;
      cnt_n   = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = NO_BLANK ? DRIVE : BLANK;
          idx_n   = 2'd0;
          cnt_n   = 16'd0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = DRIVE;
            cnt_n   = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_n = NO_BLANK ? DRIVE : BLANK;
            idx_n   = idx + 2'd1;
            cnt_n   = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = 2'd0;
          cnt_n   = 16'd0;
        end
      endcase
    end

    seg_n        = 7'd0;
    dig_en_n     = 4'd0;
    frame_done_n = 1'b0;
    if (state_n == DRIVE) begin
      dig_en_n     = 4'b0001 << idx_n;
      seg_n        = decode(nibble(active_n, idx_n));
`ifdef LEADING_ZERO_BLANK_EN
      if (lead_zero(active_n, idx_n))
        seg_n = 7'd0;
`endif
      frame_done_n = (idx_n == 2'd3) && (cnt_n == DRIVE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 2'd0;
      cnt          <= 16'd0;
      seg          <= 7'd0;
      dig_en       <= 4'd0;
      frame_done   <= 1'b0;
      active       <= 16'h0000;
      pending      <= 16'h0000;
      pending_full <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      seg        <= seg_n;
      dig_en     <= dig_en_n;
      frame_done <= frame_done_n;
      active     <= active_n;
      // A load taken on the frame_done edge sees pending_full low, so it waits a full frame.
      if (frame_done && pending_full) begin
        pending_full <= 1'b0;
      end else if (load_valid && !pending_full) begin
        pending      <= load_data;
        pending_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed vector bench for seg7_scan_ctrl (SCAN_DIV=4, BLANK_CYCLES=2)
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;

  seg7_scan_ctrl #(.SCAN_DIV(16'd4), .BLANK_CYCLES(8'd2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      data;
    logic [3:0][6:0]  s;
  } vec_t;

  vec_t vec [6];
  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total = 0;
  int bad = 0;
  int t = -1;
  logic [15:0] shown = 16'h0, pend = 16'h0;
  logic        pf = 1'b0;
  logic [6:0]  cap [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  function automatic logic [6:0] eseg(input logic [15:0] v, input int d);
    logic [3:0] n;
    n = v[d*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4*d)) == 16'd0) return 7'd0;
`endif
    return dec[n];
  endfunction

  // One clock with given inputs, then compare all outputs against the scan-position model.
  task automatic step(input logic en, input logic lv, input logic [15:0] ld, input logic rst);
    logic xfer, acc;
    int p, d, r;
    logic drive;
    enable = en; load_valid = lv; load_data = ld; reset = rst;
    @(posedge clk); #1;
    if (rst) begin
      t = -1; shown = 16'h0; pend = 16'h0; pf = 1'b0;
    end else begin
      xfer = (t >= 0) && (t % 24 == 23) && pf;
      acc  = lv && !pf;
      if (xfer) begin shown = pend; pf = 1'b0; end
      if (acc)  begin pend = ld; pf = 1'b1; end
      t = en ? t + 1 : -1;
    end
    if (t < 0) begin
      chk("seg_idle", seg, 0);
      chk("dig_en_idle", dig_en, 0);
      chk("frame_done_idle", frame_done, 0);
    end else begin
      p = t % 24; d = p / 6; r = p % 6;
      drive = (r >= 2);
      chk("dig_en", dig_en, drive ? (1 << d) : 0);
      chk("seg", seg, drive ? eseg(shown, d) : 0);
      chk("frame_done", frame_done, p == 23);
      if (drive && r == 2) cap[d] = seg;
    end
    chk("load_ready", load_ready, !pf);
  endtask

  task automatic align();
    for (int i = 0; i < 30; i++) begin
      if (t >= 0 && t % 24 == 23) return;
      step(1'b1, 1'b0, 16'h0, 1'b0);
    end
    chk("align_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic lv_first, input logic [15:0] data);
    for (int k = 0; k < 24; k++)
      step(1'b1, lv_first && k == 0, data, 1'b0);
  endtask

  initial begin
    vec[0].data = 16'h12AF; vec[0].s = {7'h06, 7'h5B, 7'h77, 7'h71};
    vec[1].data = 16'h89CE; vec[1].s = {7'h7F, 7'h6F, 7'h39, 7'h79};
    vec[2].data = 16'h3457; vec[2].s = {7'h4F, 7'h66, 7'h6D, 7'h07};
    vec[3].data = 16'hDB06; vec[3].s = {7'h5E, 7'h7C, 7'h3F, 7'h7D};
`ifdef LEADING_ZERO_BLANK_EN
    vec[4].data = 16'h0040; vec[4].s = {7'h00, 7'h00, 7'h66, 7'h3F};
    vec[5].data = 16'h0000; vec[5].s = {7'h00, 7'h00, 7'h00, 7'h3F};
`else
    vec[4].data = 16'h0040; vec[4].s = {7'h3F, 7'h3F, 7'h66, 7'h3F};
    vec[5].data = 16'h0000; vec[5].s = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif

    // Reset state.
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'hBEEF, 1'b1);
    chk("reset_load_ready", load_ready, 1);

    // Free-running scan with zero display, two full frames.
    for (int k = 0; k < 48; k++) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Table: load on the frame_done edge, shown only one frame later.
    for (int i = 0; i < 6; i++) begin
      align();
      run_frame(1'b1, vec[i].data);
      run_frame(1'b0, 16'h0);
      for (int d = 0; d < 4; d++) chk($sformatf("tbl%0d_dig%0d", i, d), cap[d], vec[i].s[d]);
    end

    // Mid-frame load, then a second load while pending is full.
    align();
    for (int k = 0; k < 24; k++)
      step(1'b1, k == 5 || k == 9, (k == 5) ? 16'h12AF : 16'h5555, 1'b0);
    run_frame(1'b0, 16'h0);
    for (int d = 0; d < 4; d++) chk($sformatf("pend_dig%0d", d), cap[d], vec[0].s[d]);
    chk("pend_ready_after", load_ready, 1);
    run_frame(1'b0, 16'h0);

    // Drop enable during digit-2 DRIVE, load while idle, then restart.
    align();
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_dig_en", dig_en, 0);
    step(1'b0, 1'b1, 16'h3457, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Reset during digit-1 DRIVE with a pending value.
    align();
    for (int k = 0; k < 9; k++) step(1'b1, k == 1, 16'h89CE, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 1'b1);
    chk("rst_mid_ready", load_ready, 1);
    chk("rst_mid_seg", seg, 0);
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
